// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, default widths and saturating arithmetic for the cook timer.
package timer_pkg;

    localparam int TIME_W_DEF   = 12;
    localparam int STEP_W_DEF   = 4;
    localparam int MAX_TIME_DEF = 4095;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2,
        EXPIRED  = 2'd3
    } state_e;

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a - b : 32'd0;
    endfunction

    // Operands are far narrower than 32 bits, so the sum cannot overflow before the clamp.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        return (a + b > max) ? max : a + b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV while enabled; TickOut flags the wrap cycle.
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic En,
    input  logic Clr,
    output logic TickOut
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign TickOut = En && (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = Clr ? '0 : !En ? cnt_q : TickOut ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable seconds countdown with saturating step decrement and expiry pulse.
// Defining TIMER_BEEP_EN adds the Beep output and its BEEP_TICKS-long hold logic.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TIME_W   = TIME_W_DEF,
    parameter int STEP_W   = STEP_W_DEF,
    parameter int TICK_DIV = 50000000,
    parameter int MAX_TIME = MAX_TIME_DEF,
    parameter int ADD_STEP = 30
`ifdef TIMER_BEEP_EN
    , parameter int BEEP_TICKS = 3
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LoadEn,
    input  logic [TIME_W-1:0] LoadValue,
    input  logic              AddEn,
    input  logic              Clear,
    input  logic              CounterEnable,
    input  logic [STEP_W-1:0] CounterInput,
    output logic [TIME_W-1:0] PresentTime,
    output logic              Tick,
    output logic              Done,
    output logic [1:0]        State
`ifdef TIMER_BEEP_EN
    , output logic            Beep
`endif
);

    state_e            state_q, state_d;
    logic [TIME_W-1:0] pt_q, pt_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic [TIME_W-1:0] load_val, add_val, sub_val;
    logic              fresh, count_en, pre_en, pre_clr, wrap, apply;

    assign fresh    = (state_q == IDLE) || (state_q == EXPIRED);
    assign count_en = (state_q == COUNTING) && CounterEnable && (pt_q != '0);
    // Adding from an idle/expired timer restarts the second boundary; mid-count adds keep it.
    assign pre_clr  = Clear || LoadEn || (AddEn && fresh);
    assign apply    = wrap && (state_q == COUNTING);

    assign load_val = TIME_W'(sat_add(32'(LoadValue), 32'd0, 32'(MAX_TIME)));
    assign add_val  = TIME_W'(sat_add(32'(pt_q), 32'(ADD_STEP), 32'(MAX_TIME)));
    assign sub_val  = TIME_W'(sat_sub(32'(pt_q), 32'(CounterInput)));

`ifdef TIMER_BEEP_EN
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

    logic          beep_q, beep_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    // The prescaler free-runs during the beep so its length is measured in seconds.
    assign pre_en = count_en || beep_q;
    assign Beep   = beep_q;

    always_comb begin
        beep_d = beep_q;
        bcnt_d = bcnt_q;
        if (Clear || LoadEn || AddEn) begin
            beep_d = 1'b0;
            bcnt_d = '0;
        end else if (done_d) begin
            beep_d = 1'b1;
            bcnt_d = '0;
        end else if (beep_q && wrap) begin
            beep_d = bcnt_q != BW'(BEEP_TICKS - 1);
            bcnt_d = bcnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_q <= 1'b0;
            bcnt_q <= '0;
        end else begin
            beep_q <= beep_d;
            bcnt_q <= bcnt_d;
        end
    end
`else
    assign pre_en = count_en;
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .En      (pre_en),
        .Clr     (pre_clr),
        .TickOut (wrap)
    );

    always_comb begin
        state_d = state_q;
        pt_d    = pt_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (Clear) begin
            pt_d    = '0;
            state_d = IDLE;
        end else if (LoadEn) begin
            pt_d    = load_val;
            state_d = (load_val != '0) ? ARMED : IDLE;
        end else if (AddEn) begin
            pt_d    = add_val;
            state_d = fresh ? ARMED : state_q;
        end else if (state_q == ARMED && CounterEnable) begin
            state_d = COUNTING;
        end else if (state_q == COUNTING && !CounterEnable) begin
            state_d = ARMED;
        end else if (apply) begin
            pt_d    = sub_val;
            tick_d  = 1'b1;
            done_d  = sub_val == '0;
            state_d = (sub_val == '0) ? EXPIRED : COUNTING;
        end else if (state_q == EXPIRED) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pt_q    <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pt_q    <= pt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign PresentTime = pt_q;
    assign Tick        = tick_q;
    assign Done        = done_q;
    assign State       = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed plus randomized checks of countdown_timer against a cycle model.
module tb_countdown_timer;

    localparam int TD = 4;
    localparam int MT = 4095;
    localparam int AS = 30;
    localparam int BT = 3;

    logic        clk = 1'b0;
    logic        rst, ld, ad, clr, ce;
    logic [11:0] lv;
    logic [3:0]  ci;
    logic [11:0] pt;
    logic        tick, done;
    logic [1:0]  state;
`ifdef TIMER_BEEP_EN
    logic        beep;
`endif

    int checks = 0;
    int failures = 0;

    int m_time, m_presc, m_state, m_beep, m_bcnt;
    bit m_tick, m_done;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(TD), .MAX_TIME(MT)) dut (
        .clk           (clk),
        .rst           (rst),
        .LoadEn        (ld),
        .LoadValue     (lv),
        .AddEn         (ad),
        .Clear         (clr),
        .CounterEnable (ce),
        .CounterInput  (ci),
        .PresentTime   (pt),
        .Tick          (tick),
        .Done          (done),
        .State         (state)
`ifdef TIMER_BEEP_EN
        , .Beep        (beep)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Modes: 0 idle, 1 armed, 2 counting, 3 expired.
    function automatic bit model_running();
        return (m_state == 2 && ce && m_time != 0) || m_beep != 0;
    endfunction

    function automatic bit model_wrap();
        return model_running() && m_presc == TD - 1;
    endfunction

    function automatic void model_update();
        bit run, wrap, fresh;
        int sub;
        run   = model_running();
        wrap  = model_wrap();
        fresh = m_state == 0 || m_state == 3;
        sub   = (m_time > int'(ci)) ? m_time - int'(ci) : 0;
        m_tick = 0;
        m_done = 0;
        if (rst) begin
            m_time = 0; m_presc = 0; m_state = 0; m_beep = 0; m_bcnt = 0;
            return;
        end
        if (clr || ld || ad) begin
            m_beep = 0; m_bcnt = 0;
        end else if (m_beep != 0 && wrap) begin
            m_bcnt++;
            if (m_bcnt == BT) m_beep = 0;
        end
        if (clr || ld || (ad && fresh)) m_presc = 0;
        else if (run) m_presc = (m_presc + 1) % TD;
        if (clr) begin
            m_time = 0; m_state = 0;
        end else if (ld) begin
            m_time  = (int'(lv) > MT) ? MT : int'(lv);
            m_state = (m_time != 0) ? 1 : 0;
        end else if (ad) begin
            m_time = (m_time + AS > MT) ? MT : m_time + AS;
            if (fresh) m_state = 1;
        end else if (m_state == 1 && ce) begin
            m_state = 2;
        end else if (m_state == 2 && !ce) begin
            m_state = 1;
        end else if (m_state == 2 && wrap) begin
            m_time = sub;
            m_tick = 1;
            if (sub == 0) begin
                m_done = 1; m_state = 3;
            end
        end else if (m_state == 3) begin
            m_state = 0;
        end
`ifdef TIMER_BEEP_EN
        if (m_done) begin
            m_beep = 1; m_bcnt = 0;
        end
`endif
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("pt", pt, m_time);
        chk("tick", tick, m_tick);
        chk("done", done, m_done);
        chk("state", state, m_state);
`ifdef TIMER_BEEP_EN
        chk("beep", beep, m_beep);
`endif
    endtask

    task automatic run_until_tick(input int lim, output int n);
        n = 0;
        while (n == 0 || (!tick && n < lim)) begin
            step();
            n++;
        end
        chk("tick_seen", tick, 1);
    endtask

    task automatic wait_wrap();
        int k = 0;
        while (!model_wrap() && k < 20) begin
            step();
            k++;
        end
        chk("wrap_reached", model_wrap(), 1);
    endtask

    initial begin
        int n, last, cnt;
        bit found;
        rst = 1; ld = 0; ad = 0; clr = 0; ce = 0; lv = 0; ci = 0;
        m_time = 0; m_presc = 0; m_state = 0; m_beep = 0; m_bcnt = 0;
        step();
        step();
        chk("reset_pt", pt, 0);
        chk("reset_state", state, 0);
        rst = 0;

        // Load 10, step 1: ticks every 4 cycles down to 0.
        ld = 1; lv = 10; step(); ld = 0; ce = 1; ci = 1;
        n = 0; last = -1; found = 0; cnt = 0;
        while (!found && n < 80) begin
            step();
            n++;
            if (tick) begin
                if (last >= 0) chk("tick_gap", n - last, 4);
                last = n;
                cnt++;
            end
            if (done) begin
                found = 1;
                chk("done_pt_zero", pt, 0);
                chk("done_state_expired", state, 3);
            end
        end
        chk("t1_done_seen", found, 1);
        chk("t1_tick_count", cnt, 10);
        step();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_state_idle", state, 0);

        // Load 7, step 5: 7 -> 2 -> 0, no wrap.
        ci = 5; ld = 1; lv = 7; step(); ld = 0;
        run_until_tick(20, n);
        chk("t2_first", pt, 2);
        chk("t2_no_done", done, 0);
        run_until_tick(20, n);
        chk("t2_sat_zero", pt, 0);
        chk("t2_done", done, 1);
        step();

        // Pause at prescaler 2 for 10 cycles.
        ci = 1; ld = 1; lv = 20; step(); ld = 0;
        n = 0;
        while (!(m_state == 2 && m_presc == 2) && n < 20) begin
            step();
            n++;
        end
        chk("t3_pt_before", pt, 20);
        ce = 0;
        repeat (10) step();
        chk("t3_paused_armed", state, 1);
        chk("t3_pt_held", pt, 20);
        ce = 1;
        run_until_tick(20, n);
        chk("t3_resume_latency", n, 3);
        chk("t3_pt_after", pt, 19);

        // Add saturation and add from IDLE.
        ce = 0; step();
        ld = 1; lv = 4090; step(); ld = 0;
        ad = 1; step(); ad = 0;
        chk("t4_add_sat", pt, 4095);
        chk("t4_armed", state, 1);
        ld = 1; lv = 0; step(); ld = 0;
        chk("t4_load0_idle", state, 0);
        ad = 1; step(); ad = 0;
        chk("t4_add_idle_pt", pt, 30);
        chk("t4_add_idle_armed", state, 1);

        // Load and add colliding with a tick.
        ld = 1; lv = 12; step(); ld = 0; ce = 1; ci = 1;
        wait_wrap();
        ld = 1; lv = 50; step(); ld = 0;
        chk("t5_load_wins", pt, 50);
        chk("t5_load_no_tick", tick, 0);
        chk("t5_load_no_done", done, 0);
        run_until_tick(20, n);
        chk("t5_presc_cleared", n, 5);
        chk("t5_pt49", pt, 49);
        wait_wrap();
        ad = 1; step(); ad = 0;
        chk("t5_add_wins", pt, 79);
        chk("t5_add_no_tick", tick, 0);
        run_until_tick(20, n);
        chk("t5_presc_wrapped", n, 4);
        chk("t5_pt78", pt, 78);
        ci = 0;
        run_until_tick(20, n);
        chk("t5_step0_pt", pt, 78);
        chk("t5_step0_gap", n, 4);
        rst = 1; step(); rst = 0;
        chk("t5_rst_pt", pt, 0);
        chk("t5_rst_state", state, 0);
        chk("t5_rst_done", done, 0);

`ifdef TIMER_BEEP_EN
        ci = 1; ld = 1; lv = 1; step(); ld = 0;
        n = 0;
        while (!done && n < 20) begin step(); n++; end
        chk("t6_done_seen", done, 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (beep) cnt++;
            step();
        end
        chk("t6_beep_len", cnt, 12);
        ld = 1; lv = 1; step(); ld = 0;
        n = 0;
        while (!done && n < 20) begin step(); n++; end
        repeat (3) step();
        chk("t6_beep_still", beep, 1);
        clr = 1; step(); clr = 0;
        chk("t6_beep_cleared", beep, 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst = $urandom_range(0, 199) == 0;
            clr = $urandom_range(0, 39) == 0;
            ld  = $urandom_range(0, 19) == 0;
            ad  = $urandom_range(0, 24) == 0;
            ce  = $urandom_range(0, 99) < 85;
            lv  = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 60));
            ci  = 4'($urandom_range(0, 6));
            step();
        end
        rst = 0; clr = 0; ld = 0; ad = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
